lfsr_prbs_checker: RTL and testbench

- Downstream consumer of the n-bit LFSR generator: receives its parallel output word stream plus its done strobe.
- Self-synchronises to the sequence, declares lock, then counts sequence errors for link/datapath BIST.
- Uses the same Fibonacci XNOR next-state rule as the generator, so the two can be wired back-to-back or across a datapath under test.

---
 rtl/lfsr_prbs_checker.sv | 157 +++++++++++++++
 tb/tb_lfsr_prbs_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_checker.sv
// PRBS checker for the Fibonacci XNOR LFSR stream: self-synchronises, locks, counts errors.
// Optional period check on the generator's done strobe when LFSR_PERIOD_CHECK_EN is defined.
module lfsr_prbs_checker #(
    parameter int                  NUM_BITS = 4,
    parameter logic [NUM_BITS-1:0] TAPS     = 4'b1100,
    parameter int                  LOCK_CNT = 4,
    parameter int                  LOSS_CNT = 3,
    parameter int                  ERR_W    = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Clear,
    input  logic                i_Valid,
    input  logic [NUM_BITS-1:0] i_Data,
    input  logic                i_Done,
    output logic                o_Locked,
    output logic                o_Err,
    output logic [ERR_W-1:0]    o_Err_Count,
`ifdef LFSR_PERIOD_CHECK_EN
    output logic                o_Period_Err,
`endif
    output logic                o_Lockup
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int XW = $clog2(LOSS_CNT + 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t              state, state_n;
    logic [NUM_BITS-1:0] prev, prev_n;
    logic                prev_vld, prev_vld_n;
    logic [MW-1:0]       match_cnt, match_cnt_n;
    logic [XW-1:0]       miss_cnt, miss_cnt_n;
    logic [ERR_W-1:0]    err_cnt, err_cnt_n;
    logic                err_n, lockup_n;
    logic [NUM_BITS-1:0] predict;
    logic                all_ones, hit;

    assign predict  = {prev[NUM_BITS-2:0], ~^(prev & TAPS)};
    assign all_ones = &i_Data;
    assign hit      = prev_vld && (i_Data == predict) && !all_ones;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= SEARCH;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        prev_n      = prev;
        prev_vld_n  = prev_vld;
        match_cnt_n = match_cnt;
        miss_cnt_n  = miss_cnt;
        err_cnt_n   = err_cnt;
        err_n       = 1'b0;
        lockup_n    = o_Lockup;
        if (i_Clear) begin
            state_n     = SEARCH;
            prev_vld_n  = 1'b0;
            match_cnt_n = '0;
            miss_cnt_n  = '0;
            err_cnt_n   = '0;
            lockup_n    = 1'b0;
        end else if (i_Valid) begin
            // Always resync to the received word, so one bad word costs two mismatches.
            prev_n     = i_Data;
            prev_vld_n = 1'b1;
            if (all_ones) lockup_n = 1'b1;
            case (state)
                SEARCH: begin
                    if (!hit) begin
                        match_cnt_n = '0;
                    end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
                        state_n     = LOCKED;
                        match_cnt_n = '0;
                        miss_cnt_n  = '0;
                    end else begin
                        match_cnt_n = match_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        miss_cnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                        if (!(&err_cnt)) err_cnt_n = err_cnt + 1'b1;
                        if (miss_cnt == XW'(LOSS_CNT - 1)) begin
                            state_n     = SEARCH;
                            match_cnt_n = '0;
                            miss_cnt_n  = '0;
                        end else begin
                            miss_cnt_n = miss_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            prev      <= '0;
            prev_vld  <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_cnt   <= '0;
            o_Err     <= 1'b0;
            o_Lockup  <= 1'b0;
            o_Locked  <= 1'b0;
        end else begin
            prev      <= prev_n;
            prev_vld  <= prev_vld_n;
            match_cnt <= match_cnt_n;
            miss_cnt  <= miss_cnt_n;
            err_cnt   <= err_cnt_n;
            o_Err     <= err_n;
            o_Lockup  <= lockup_n;
            o_Locked  <= (state_n == LOCKED);
        end
    end

    assign o_Err_Count = err_cnt;

`ifdef LFSR_PERIOD_CHECK_EN
    logic [NUM_BITS-1:0] per_cnt;
    logic                armed;

    // First done after lock only establishes the phase; later dones are checked.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            per_cnt      <= '0;
            armed        <= 1'b0;
            o_Period_Err <= 1'b0;
        end else begin
            if (i_Clear) begin
                o_Period_Err <= 1'b0;
            end else if (i_Valid) begin
                if (i_Done) begin
                    per_cnt <= NUM_BITS'(1);
                    if (state == LOCKED) begin
                        armed <= 1'b1;
                        if (armed && !(&per_cnt)) o_Period_Err <= 1'b1;
                    end
                end else if (!(&per_cnt)) begin
                    per_cnt <= per_cnt + 1'b1;
                end
            end
            if (state_n != LOCKED) armed <= 1'b0;
        end
    end
`else
    logic unused_done;
    assign unused_done = i_Done;
`endif

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Self-checking bench for lfsr_prbs_checker: directed test-plan steps plus a random stream,
// all compared against a sample-level behavioural model.
module tb_lfsr_prbs_checker;
    localparam int         NB    = 4;
    localparam logic [3:0] TAPS  = 4'b1100;
    localparam int         LOCKN = 4;
    localparam int         LOSSN = 3;
    localparam int         EW    = 4;
    localparam int         EMAX  = (1 << EW) - 1;

    logic          i_Clk = 1'b0;
    logic          i_Rst_n = 1'b0;
    logic          i_Clear = 1'b0;
    logic          i_Valid = 1'b0;
    logic [NB-1:0] i_Data = '0;
    logic          i_Done = 1'b0;
    logic          o_Locked, o_Err, o_Lockup;
    logic [EW-1:0] o_Err_Count;
`ifdef LFSR_PERIOD_CHECK_EN
    logic          o_Period_Err;
`endif

    lfsr_prbs_checker #(.NUM_BITS(NB), .TAPS(TAPS), .LOCK_CNT(LOCKN), .LOSS_CNT(LOSSN), .ERR_W(EW)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Clear(i_Clear), .i_Valid(i_Valid),
        .i_Data(i_Data), .i_Done(i_Done), .o_Locked(o_Locked), .o_Err(o_Err),
        .o_Err_Count(o_Err_Count),
`ifdef LFSR_PERIOD_CHECK_EN
        .o_Period_Err(o_Period_Err),
`endif
        .o_Lockup(o_Lockup));

    always #5 i_Clk = ~i_Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: one update per clocked sample.
    logic [NB-1:0] m_prev;
    bit  m_pv, m_locked, m_err, m_lockup, m_armed, m_perr;
    int  m_run, m_miss, m_cnt, m_pc;
    logic [NB-1:0] g;

    function automatic logic [NB-1:0] nxt(input logic [NB-1:0] p);
        return {p[NB-2:0], ($countones(p & TAPS) % 2) == 0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit v, input logic [NB-1:0] d, input bit dn, input bit clr);
        bit ok, was_locked;
        m_err = 0;
        was_locked = m_locked;
        if (clr) begin
            m_pv = 0; m_locked = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_lockup = 0; m_perr = 0;
        end else if (v) begin
            ok = m_pv && (d == nxt(m_prev)) && (d != 4'hF);
            if (d == 4'hF) m_lockup = 1;
            if (!m_locked) begin
                m_run = ok ? m_run + 1 : 0;
                if (m_run == LOCKN) begin m_locked = 1; m_run = 0; m_miss = 0; end
            end else if (ok) begin
                m_miss = 0;
            end else begin
                m_err = 1;
                m_cnt = (m_cnt < EMAX) ? m_cnt + 1 : EMAX;
                m_miss++;
                if (m_miss == LOSSN) begin m_locked = 0; m_run = 0; m_miss = 0; end
            end
            if (dn) begin
                if (was_locked && m_armed && m_pc != (1 << NB) - 1) m_perr = 1;
                if (was_locked) m_armed = 1;
                m_pc = 1;
            end else if (m_pc < (1 << NB) - 1) begin
                m_pc++;
            end
            m_prev = d; m_pv = 1;
        end
        if (!m_locked) m_armed = 0;
    endtask

    task automatic check_all();
        chk("locked", 32'(o_Locked), 32'(m_locked));
        chk("err", 32'(o_Err), 32'(m_err));
        chk("err_count", 32'(o_Err_Count), 32'(m_cnt));
        chk("lockup", 32'(o_Lockup), 32'(m_lockup));
`ifdef LFSR_PERIOD_CHECK_EN
        chk("period_err", 32'(o_Period_Err), 32'(m_perr));
`endif
    endtask

    task automatic send(input bit v, input logic [NB-1:0] d, input bit dn, input bit clr);
        @(negedge i_Clk);
        i_Valid = v; i_Data = d; i_Done = dn; i_Clear = clr;
        @(posedge i_Clk);
        model(v, d, dn, clr);
        #1;
        check_all();
    endtask

    // Seed word followed by LOCK_CNT correct predictions.
    task automatic lock_from(input logic [NB-1:0] seed);
        g = seed;
        send(1, g, 0, 0);
        for (int i = 0; i < LOCKN; i++) begin
            g = nxt(g);
            send(1, g, 0, 0);
        end
    endtask

    initial begin
        logic [NB-1:0] w;
        m_prev = '0; m_pv = 0; m_locked = 0; m_err = 0; m_lockup = 0; m_armed = 0; m_perr = 0;
        m_run = 0; m_miss = 0; m_cnt = 0; m_pc = 0;

        #2;
        check_all();
        chk("reset_locked", 32'(o_Locked), 0);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;

        // Lock on 0000,0001,0011,0111,1110
        lock_from(4'h0);
        chk("tp_lock_word", 32'(g), 32'hE);
        chk("tp_locked", 32'(o_Locked), 1);
        chk("tp_lock_cnt", 32'(o_Err_Count), 0);

        // Single flipped word -> two mismatches, lock held
        g = nxt(g);
        send(1, g ^ 4'h1, 0, 0);
        chk("tp_single_pulse", 32'(o_Err), 1);
        g = nxt(g);
        send(1, g, 0, 0);
        g = nxt(g);
        send(1, g, 0, 0);
        chk("tp_single_cnt", 32'(o_Err_Count), 2);
        chk("tp_single_locked", 32'(o_Locked), 1);

        // Loss of lock after three garbage words, then relock
        send(0, 4'h0, 0, 1);
        lock_from(4'h3);
        for (int i = 0; i < LOSSN; i++) begin
            do w = nxt(g) ^ 4'($urandom_range(1, 15)); while (w == 4'hF);
            g = w;
            send(1, g, 0, 0);
        end
        chk("tp_loss_cnt", 32'(o_Err_Count), 3);
        chk("tp_loss_unlocked", 32'(o_Locked), 0);
        for (int i = 0; i < LOCKN; i++) begin
            g = nxt(g);
            send(1, g, 0, 0);
        end
        chk("tp_relock", 32'(o_Locked), 1);

        // Lockup word
        send(0, 4'h0, 0, 1);
        for (int i = 0; i < 6; i++) send(1, 4'hF, 0, 0);
        chk("tp_lockup", 32'(o_Lockup), 1);
        chk("tp_lockup_nolock", 32'(o_Locked), 0);
        send(0, 4'h0, 0, 1);
        chk("tp_lockup_clr", 32'(o_Lockup), 0);
        chk("tp_lockup_clr_cnt", 32'(o_Err_Count), 0);

        // Gapped valid
        g = 4'h5;
        send(1, g, 0, 0);
        for (int i = 0; i < LOCKN; i++) begin
            send(0, 4'hA, 0, 0);
            g = nxt(g);
            send(1, g, 0, 0);
        end
        chk("tp_gap_locked", 32'(o_Locked), 1);
        chk("tp_gap_cnt", 32'(o_Err_Count), 0);

        // Saturation: bad word then its own successor, twenty times
        for (int i = 0; i < 20; i++) begin
            w = nxt(g) ^ 4'h1;
            if (w == 4'hF) w = nxt(g) ^ 4'h2;
            g = w;
            send(1, g, 0, 0);
            g = nxt(g);
            send(1, g, 0, 0);
        end
        chk("tp_sat", 32'(o_Err_Count), EMAX);
        chk("tp_sat_locked", 32'(o_Locked), 1);

        // Clear colliding with a sample: clear wins
        send(1, 4'hF, 0, 1);
        chk("tp_clr_prio_lockup", 32'(o_Lockup), 0);

`ifdef LFSR_PERIOD_CHECK_EN
        g = 4'h0;
        for (int i = 0; i < 45; i++) begin
            send(1, g, (i % 15) == 14, 0);
            g = nxt(g);
        end
        chk("tp_period_ok", 32'(o_Period_Err), 0);
        for (int j = 1; j <= 14; j++) begin
            send(1, g, j == 14, 0);
            g = nxt(g);
        end
        chk("tp_period_bad", 32'(o_Period_Err), 1);
        send(1, g, 0, 0);
        chk("tp_period_sticky", 32'(o_Period_Err), 1);
        send(0, 4'h0, 0, 1);
`endif

        // Random stream with injected errors, gaps, dones and rare clears
        g = 4'($urandom_range(0, 14));
        for (int i = 0; i < 600; i++) begin
            bit v, clr, dn;
            v   = $urandom_range(0, 3) != 0;
            clr = $urandom_range(0, 99) == 0;
            dn  = $urandom_range(0, 7) == 0;
            w   = g;
            if (v) begin
                g = nxt(g);
                w = g;
                if ($urandom_range(0, 11) == 0) w = g ^ 4'($urandom_range(1, 15));
            end
            send(v, w, dn, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
